data_mem_responder: RTL

// - Responder end of the CPU data-memory interface: accepts one load/store request at a time over valid/ready,

---
 rtl/brisc_pkg.sv | 43 ++++
 rtl/mem_lane_align.sv | 78 +++++++
 rtl/data_mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// -----------------------------------------------------------------------------
// brisc_pkg
// Shared definitions for the data-memory responder:
//   - DATA_W          : datapath width (32)
//   - F3_*            : RISC-V funct3 access-size codes
//   - state_e         : responder FSM state encoding (IDLE/BUSY/RESP)
//   - f3_fault()      : funct3/alignment legality check for one access
// -----------------------------------------------------------------------------
package brisc_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Returns 1 when the funct3 code is illegal for this direction or the
  // low address bits are not naturally aligned for the access size.
  // The address-range check is separate because it depends on storage depth.
  function automatic logic f3_fault(input logic [2:0] f3,
                                    input logic       we,
                                    input logic [1:0] addr_lo);
    logic fault;
    case (f3)
      F3_B:    fault = 1'b0;
      F3_BU:   fault = we;
      F3_H:    fault = addr_lo[0];
      F3_HU:   fault = we | addr_lo[0];
      F3_W:    fault = (addr_lo != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational lane steering between a 32-bit storage word and the CPU view.
//   i_f3        : funct3 access size / signedness
//   i_addr_lo   : byte offset within the word
//   i_rword     : word read from storage
//   i_wdata     : right-aligned store data from the CPU
//   o_rdata     : load result, lane-extracted and sign/zero-extended
//   o_be        : byte enables for a store (all zero for unknown funct3)
//   o_wdata_rep : store data replicated onto every lane it could occupy
// -----------------------------------------------------------------------------
module mem_lane_align
  import brisc_pkg::*;
(
  input  logic [2:0]        i_f3,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_rword,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata_rep
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: pick the addressed byte/half and extend it.
  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    o_rdata = '0;
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rword[31:16];
    end else begin
      w_half = i_rword[15:0];
    end
    case (i_f3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h000000, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0000, w_half};
      F3_W:    o_rdata = i_rword;
      default: o_rdata = '0;
    endcase
  end

  // Store path: byte enables and lane replication; only enabled lanes matter.
  always_comb begin
    o_be        = 4'b0000;
    o_wdata_rep = '0;
    case (i_f3)
      F3_B: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
      end
      default: begin
        o_be        = 4'b0000;
        o_wdata_rep = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Responder end of the CPU data-memory interface. Accepts one load/store at a
// time, performs it against word-organised storage after LATENCY cycles and
// holds the response until the CPU takes it.
//   clk, rst        : clock, asynchronous active-low reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   req_we/f3/addr/wdata : request fields (store data right-aligned)
//   resp_valid/ready: response handshake (valid held until ready)
//   resp_rdata      : extended load data; 0 for stores and errors
//   resp_err        : misaligned, out-of-range or illegal funct3
// -----------------------------------------------------------------------------
module data_mem_responder
  import brisc_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          ADDR_MSB   = IDX_W + 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(64'(DEPTH_WORDS) * 64'd4);
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("data_mem_responder: LATENCY must be within 1..15");
  end

  state_e            r_state;
  state_e            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_access;
  logic              w_err;
  logic              w_commit;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_ld_data;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata_rep;

  assign w_accept = (r_state == IDLE) && req_valid;
  // The access happens on the edge that leaves BUSY.
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_err    = f3_fault(r_f3, r_we, r_addr[1:0]) || ({1'b0, r_addr} >= ADDR_LIMIT);
  assign w_commit = w_access && r_we && !w_err;
  assign w_idx    = r_addr[ADDR_MSB:2];
  assign w_word   = r_mem[w_idx];

  mem_lane_align u_align (
    .i_f3        (r_f3),
    .i_addr_lo   (r_addr[1:0]),
    .i_rword     (w_word),
    .i_wdata     (r_wdata),
    .o_rdata     (w_ld_data),
    .o_be        (w_be),
    .o_wdata_rep (w_wdata_rep)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next = RESP;
        end else begin
          w_next = BUSY;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_next = IDLE;
        end else begin
          w_next = RESP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready  = 1'b1;
      BUSY:    req_ready  = 1'b0;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Latency counter: loaded on accept, counts down while BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture; fields are only sampled in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_f3    <= req_f3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Response registers, updated on the access edge and held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_we) ? '0 : w_ld_data;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Byte-lane store commit; storage contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) begin
          r_mem[w_idx][8*l +: 8] <= w_wdata_rep[8*l +: 8];
        end
      end
    end
  end

endmodule
